// File: rtl/decode_ctrl_pipe.sv
// Instruction decode to registered control word, with a two-state mul/div handshake.
// Optional build macro CTRL_MD_TIMEOUT_EN adds an MD_WAIT abort after MD_TIMEOUT cycles.
module decode_ctrl_pipe #(
  parameter int OP_W       = 5,
  parameter int ALU_W      = 5,
  parameter int MD_TIMEOUT = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [OP_W-1:0]  opcode,
  input  logic [ALU_W-1:0] aluop_in,
  input  logic             stall_in,
  input  logic             md_ready,
  output logic             stall_out,
  output logic             ctrl_valid,
  output logic [ALU_W-1:0] aluop,
  output logic             aluInB,
  output logic             RWE,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             md_start,
  output logic             md_is_div,
  output logic             md_error
);

  // Handshake: an instruction is taken on a clock edge where instr_valid=1 and
  // stall_out=0; a presented control word is held while stall_in=1.
  typedef enum logic {IDLE, MD_WAIT} state_t;

  localparam logic [OP_W-1:0]  OPC_R    = OP_W'(0);
  localparam logic [OP_W-1:0]  OPC_ADDI = OP_W'(5);
  localparam logic [OP_W-1:0]  OPC_SW   = OP_W'(7);
  localparam logic [OP_W-1:0]  OPC_LW   = OP_W'(8);
  localparam logic [ALU_W-1:0] ALU_MUL  = ALU_W'(6);
  localparam logic [ALU_W-1:0] ALU_DIV  = ALU_W'(7);

  state_t             r_state, w_state_nxt;
  logic               r_ctrl_valid, w_ctrl_valid_nxt;
  logic [ALU_W-1:0]   r_aluop, w_aluop_nxt;
  logic               r_aluinb, w_aluinb_nxt;
  logic               r_rwe, w_rwe_nxt;
  logic               r_mem_rd, w_mem_rd_nxt;
  logic               r_mem_wr, w_mem_wr_nxt;
  logic               r_md_start, w_md_start_nxt;
  logic               r_md_is_div, w_md_is_div_nxt;
  logic [ALU_W-1:0]   r_md_op, w_md_op_nxt;
  logic               w_hold, w_stall, w_accept, w_is_md;

`ifdef CTRL_MD_TIMEOUT_EN
  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_md_error, w_md_error_nxt;
`else
  logic [31:0]        w_unused_md_timeout;
  assign w_unused_md_timeout = MD_TIMEOUT;
`endif

  always_comb begin
    w_hold   = r_ctrl_valid & stall_in;
    w_stall  = (r_state == MD_WAIT) | w_hold;
    w_accept = instr_valid & ~w_stall;
    w_is_md  = (opcode == OPC_R) && ((aluop_in == ALU_MUL) || (aluop_in == ALU_DIV));

    w_state_nxt      = r_state;
    w_ctrl_valid_nxt = 1'b0;
    w_aluop_nxt      = '0;
    w_aluinb_nxt     = 1'b0;
    w_rwe_nxt        = 1'b0;
    w_mem_rd_nxt     = 1'b0;
    w_mem_wr_nxt     = 1'b0;
    w_md_start_nxt   = 1'b0;
    w_md_is_div_nxt  = 1'b0;
    w_md_op_nxt      = r_md_op;
`ifdef CTRL_MD_TIMEOUT_EN
    w_cnt_nxt        = r_cnt;
    w_md_error_nxt   = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (w_hold) begin
          w_ctrl_valid_nxt = r_ctrl_valid;
          w_aluop_nxt      = r_aluop;
          w_aluinb_nxt     = r_aluinb;
          w_rwe_nxt        = r_rwe;
          w_mem_rd_nxt     = r_mem_rd;
          w_mem_wr_nxt     = r_mem_wr;
        end else if (w_accept) begin
          if (w_is_md) begin
            // Launch only; the result word appears after md_ready in MD_WAIT.
            w_md_start_nxt  = 1'b1;
            w_md_is_div_nxt = (aluop_in == ALU_DIV);
            w_md_op_nxt     = aluop_in;
            w_state_nxt     = MD_WAIT;
`ifdef CTRL_MD_TIMEOUT_EN
            w_cnt_nxt       = '0;
`endif
          end else begin
            w_ctrl_valid_nxt = 1'b1;
            case (opcode)
              OPC_R: begin
                w_aluop_nxt = aluop_in;
                w_rwe_nxt   = 1'b1;
              end
              OPC_ADDI: begin
                w_aluinb_nxt = 1'b1;
                w_rwe_nxt    = 1'b1;
              end
              OPC_LW: begin
                w_aluinb_nxt = 1'b1;
                w_rwe_nxt    = 1'b1;
                w_mem_rd_nxt = 1'b1;
              end
              OPC_SW: begin
                w_aluinb_nxt = 1'b1;
                w_mem_wr_nxt = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      MD_WAIT: begin
        if (md_ready) begin
          w_ctrl_valid_nxt = 1'b1;
          w_aluop_nxt      = r_md_op;
          w_rwe_nxt        = 1'b1;
          w_state_nxt      = IDLE;
`ifdef CTRL_MD_TIMEOUT_EN
        end else if (r_cnt == CNT_W'(MD_TIMEOUT)) begin
          w_ctrl_valid_nxt = 1'b1;
          w_md_error_nxt   = 1'b1;
          w_state_nxt      = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ctrl_valid <= 1'b0;
      r_aluop      <= '0;
      r_aluinb     <= 1'b0;
      r_rwe        <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_md_start   <= 1'b0;
      r_md_is_div  <= 1'b0;
      r_md_op      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ctrl_valid <= w_ctrl_valid_nxt;
      r_aluop      <= w_aluop_nxt;
      r_aluinb     <= w_aluinb_nxt;
      r_rwe        <= w_rwe_nxt;
      r_mem_rd     <= w_mem_rd_nxt;
      r_mem_wr     <= w_mem_wr_nxt;
      r_md_start   <= w_md_start_nxt;
      r_md_is_div  <= w_md_is_div_nxt;
      r_md_op      <= w_md_op_nxt;
    end
  end

`ifdef CTRL_MD_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_md_error <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_md_error <= w_md_error_nxt;
    end
  end
  assign md_error = r_md_error;
`else
  assign md_error = 1'b0;
`endif

  assign stall_out  = w_stall;
  assign ctrl_valid = r_ctrl_valid;
  assign aluop      = r_aluop;
  assign aluInB     = r_aluinb;
  assign RWE        = r_rwe;
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;
  assign md_start   = r_md_start;
  assign md_is_div  = r_md_is_div;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Self-checking bench for decode_ctrl_pipe: directed scenarios then random traffic
// against a cycle-level reference model of the decode/mul-div rules.
module tb_decode_ctrl_pipe;

  localparam int OP_W  = 5;
  localparam int ALU_W = 5;
`ifdef CTRL_MD_TIMEOUT_EN
  localparam int TO     = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TO     = 32;
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int WW = ALU_W + 8;

  logic             clock, reset, instr_valid, stall_in, md_ready;
  logic [OP_W-1:0]  opcode;
  logic [ALU_W-1:0] aluop_in, aluop;
  logic             stall_out, ctrl_valid, aluInB, RWE, mem_rd, mem_wr;
  logic             md_start, md_is_div, md_error;

  decode_ctrl_pipe #(.OP_W(OP_W), .ALU_W(ALU_W), .MD_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .aluop_in(aluop_in), .stall_in(stall_in), .md_ready(md_ready),
    .stall_out(stall_out), .ctrl_valid(ctrl_valid), .aluop(aluop), .aluInB(aluInB),
    .RWE(RWE), .mem_rd(mem_rd), .mem_wr(mem_wr), .md_start(md_start),
    .md_is_div(md_is_div), .md_error(md_error)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] w_obs;
  assign w_obs = {ctrl_valid, aluop, aluInB, RWE, mem_rd, mem_wr, md_start, md_is_div, md_error};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: "busy" means a mul/div is outstanding
  bit               m_known = 0;
  bit               m_busy  = 0;
  logic [ALU_W-1:0] m_op    = '0;
  int               m_cnt   = 0;
  logic             e_cv = 0, e_inb = 0, e_rwe = 0, e_rd = 0, e_wr = 0;
  logic             e_start = 0, e_div = 0, e_err = 0;
  logic [ALU_W-1:0] e_alu = '0;

  task automatic model_step();
    logic n_cv, n_inb, n_rwe, n_rd, n_wr, n_start, n_div, n_err;
    logic [ALU_W-1:0] n_alu;
    bit hold;
    hold = e_cv && stall_in;
    {n_cv, n_inb, n_rwe, n_rd, n_wr, n_start, n_div, n_err} = '0;
    n_alu = '0;
    if (reset) begin
      m_busy  = 0;
      m_known = 1;
    end else if (m_busy) begin
      if (md_ready) begin
        n_cv = 1; n_alu = m_op; n_rwe = 1; m_busy = 0;
      end else if (TMO_EN && m_cnt == TO) begin
        n_cv = 1; n_err = 1; m_busy = 0;
      end else begin
        m_cnt++;
      end
    end else if (hold) begin
      n_cv = e_cv; n_alu = e_alu; n_inb = e_inb; n_rwe = e_rwe; n_rd = e_rd; n_wr = e_wr;
    end else if (instr_valid) begin
      case (opcode)
        5'd0: begin
          if (aluop_in == 5'd6 || aluop_in == 5'd7) begin
            n_start = 1; n_div = (aluop_in == 5'd7); m_op = aluop_in; m_busy = 1; m_cnt = 0;
          end else begin
            n_cv = 1; n_alu = aluop_in; n_rwe = 1;
          end
        end
        5'd5: begin n_cv = 1; n_inb = 1; n_rwe = 1; end
        5'd8: begin n_cv = 1; n_inb = 1; n_rwe = 1; n_rd = 1; end
        5'd7: begin n_cv = 1; n_inb = 1; n_wr = 1; end
        default: n_cv = 1;
      endcase
    end
    {e_cv, e_alu, e_inb, e_rwe, e_rd, e_wr, e_start, e_div, e_err} =
      {n_cv, n_alu, n_inb, n_rwe, n_rd, n_wr, n_start, n_div, n_err};
    exp_q.push_back({e_cv, e_alu, e_inb, e_rwe, e_rd, e_wr, e_start, e_div, e_err});
  endtask

  // driver: one clock cycle of stimulus, starting and ending just after a negedge
  task automatic cycle(input string tag, input bit rst, input bit iv, input logic [4:0] op,
                       input logic [4:0] alu, input bit st, input bit mr);
    reset = rst; instr_valid = iv; opcode = op; aluop_in = alu; stall_in = st; md_ready = mr;
    #1;
    if (m_known) check({tag, "_stall_out"}, stall_out, m_busy | (e_cv & st));
    @(posedge clock);
    model_step();
    @(negedge clock);
    check({tag, "_ctrl_word"}, w_obs, exp_q.pop_front());
  endtask

  int nerr;

  initial begin
    reset = 1; instr_valid = 0; opcode = '0; aluop_in = '0; stall_in = 0; md_ready = 0;
    @(negedge clock);
    cycle("reset", 1, 0, 0, 0, 0, 0);
    cycle("reset", 1, 1, 5, 0, 0, 1);
    check("reset_ctrl_valid", ctrl_valid, 0);
    check("reset_stall_out", stall_out, 0);

    // addi: one cycle latency
    cycle("addi", 0, 1, 5'd5, 5'd3, 0, 0);
    check("addi_word", {ctrl_valid, aluInB, RWE, aluop}, {3'b111, 5'd0});
    cycle("idle", 0, 0, 0, 0, 0, 0);
    check("idle_clear", ctrl_valid, 0);

    // mul: md_start at cycle 1, md_ready at cycle 5, result at cycle 6
    cycle("mul_acc", 0, 1, 5'd0, 5'd6, 0, 0);
    check("mul_start", {md_start, md_is_div, stall_out}, 3'b101);
    for (int i = 0; i < 4; i++) cycle("mul_wait", 0, 1, 5'd5, 0, 0, 0);
    cycle("mul_rdy", 0, 0, 0, 0, 0, 1);
    check("mul_result", {ctrl_valid, RWE, aluInB, aluop}, {3'b110, 5'd6});
    check("mul_stall_clear", stall_out, 0);

    // sw held by stall_in for 3 cycles, lw presented next
    cycle("sw", 0, 1, 5'd7, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("sw_hold", 0, 1, 5'd8, 0, 1, 0);
      check("sw_held", {ctrl_valid, mem_wr, RWE}, 3'b110);
    end
    cycle("lw", 0, 1, 5'd8, 0, 0, 0);
    check("lw_word", {ctrl_valid, mem_rd, RWE, aluInB}, 4'b1111);
    cycle("idle", 0, 0, 0, 0, 0, 0);

    // reset while a div is pending discards it
    cycle("div_acc", 0, 1, 5'd0, 5'd7, 0, 0);
    check("div_is_div", md_is_div, 1);
    cycle("div_wait", 0, 0, 0, 0, 0, 0);
    cycle("div_reset", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("post_reset_rdy", 0, 0, 0, 0, 0, 1);
      check("post_reset_quiet", w_obs, '0);
    end

`ifdef CTRL_MD_TIMEOUT_EN
    nerr = 0;
    cycle("tmo_acc", 0, 1, 5'd0, 5'd7, 0, 0);
    for (int i = 0; i < TO + 6; i++) begin
      cycle("tmo_wait", 0, 0, 0, 0, 0, 0);
      if (md_error) begin
        nerr++;
        check("tmo_word", {ctrl_valid, RWE}, 2'b10);
      end
    end
    check("tmo_err_once", nerr, 1);
    check("tmo_idle", stall_out, 0);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] op, alu;
      case ($urandom_range(0, 5))
        0, 1:    op = 5'd0;
        2:       op = 5'd5;
        3:       op = 5'd7;
        4:       op = 5'd8;
        default: op = 5'($urandom_range(0, 31));
      endcase
      alu = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(6, 7)) : 5'($urandom_range(0, 31));
      cycle("rand", $urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, op, alu,
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
